led_mode_ctrl: RTL and testbench

LED_MODE_CTRL -- requirements
Module: led_mode_ctrl

---
 rtl/led_ctrl_pkg.sv | 20 ++
 rtl/btn_debounce.sv | 59 +++++
 rtl/led_mode_ctrl.sv | 86 ++++++++
 tb/tb_led_mode_ctrl.sv | 163 ++++++++++++++++
 4 files changed

// File: rtl/led_ctrl_pkg.sv
`default_nettype none
// ============================================================================
// Module : led_ctrl_pkg
// Brief  : Mode encoding and debounce defaults shared with the blink stage.
// Rev    : 1.0 - initial release
// ============================================================================
package led_ctrl_pkg;

    typedef enum logic [1:0] {
        MODE_OFF    = 2'b00,
        MODE_STEADY = 2'b01,
        MODE_BLINK  = 2'b10
    } mode_e;

    // 10 ms at 100 MHz
    localparam int unsigned DEBOUNCE_DEFAULT = 1000000;
    localparam int unsigned CNT_W_DEFAULT    = 20;

endpackage
`default_nettype wire

// File: rtl/btn_debounce.sv
`default_nettype none
// ============================================================================
// Module : btn_debounce
// Brief  : Two-flop synchronizer, stability counter and rising-edge press pulse.
// Rev    : 1.0 - initial release
// ============================================================================
module btn_debounce
    import led_ctrl_pkg::*;
#(
    parameter int unsigned DEBOUNCE_CYCLES = DEBOUNCE_DEFAULT,
    parameter int unsigned CNT_W           = CNT_W_DEFAULT
) (
    input  logic clk,
    input  logic rst_n,
    input  logic i_btn,
    output logic o_press
);

    localparam logic [CNT_W-1:0] c_CNT_LAST = CNT_W'(DEBOUNCE_CYCLES - 1);

    logic             r_sync1;
    logic             r_sync2;
    logic             r_level;
    logic             r_level_d;
    logic             r_press;
    logic [CNT_W-1:0] r_cnt;
    logic             w_differ;

    assign w_differ = r_sync2 ^ r_level;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_sync1   <= 1'b0;
            r_sync2   <= 1'b0;
            r_level   <= 1'b0;
            r_level_d <= 1'b0;
            r_press   <= 1'b0;
            r_cnt     <= '0;
        end else begin
            r_sync1   <= i_btn;
            r_sync2   <= r_sync1;
            // Any return to the accepted level restarts the stability window
            if (!w_differ) begin
                r_cnt <= '0;
            end else if (r_cnt == c_CNT_LAST) begin
                r_level <= r_sync2;
                r_cnt   <= '0;
            end else begin
                r_cnt <= r_cnt + 1'b1;
            end
            r_level_d <= r_level;
            r_press   <= r_level & ~r_level_d;
        end
    end

    assign o_press = r_press;

endmodule
`default_nettype wire

// File: rtl/led_mode_ctrl.sv
`default_nettype none
// ============================================================================
// Module : led_mode_ctrl
// Brief  : Debounced on/off buttons drive an OFF/STEADY/BLINK mode FSM.
// Rev    : 1.0 - initial release
// ============================================================================
module led_mode_ctrl
    import led_ctrl_pkg::*;
#(
    parameter int unsigned DEBOUNCE_CYCLES = DEBOUNCE_DEFAULT,
    parameter int unsigned CNT_W           = CNT_W_DEFAULT
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       btn_on,
    input  logic       btn_off,
    output logic [1:0] mode,
    output logic       led_force,
    output logic       blink_en,
    output logic       mode_chg
);

    logic  w_on_press;
    logic  w_off_press;
    mode_e r_mode;
    mode_e w_mode_nxt;
    logic  r_led_force;
    logic  r_blink_en;
    logic  r_mode_chg;

    btn_debounce #(
        .DEBOUNCE_CYCLES (DEBOUNCE_CYCLES),
        .CNT_W           (CNT_W)
    ) u_dbnc_on (
        .clk     (clk),
        .rst_n   (rst_n),
        .i_btn   (btn_on),
        .o_press (w_on_press)
    );

    btn_debounce #(
        .DEBOUNCE_CYCLES (DEBOUNCE_CYCLES),
        .CNT_W           (CNT_W)
    ) u_dbnc_off (
        .clk     (clk),
        .rst_n   (rst_n),
        .i_btn   (btn_off),
        .o_press (w_off_press)
    );

    always_comb begin
        w_mode_nxt = r_mode;
        // Off has priority over a coincident on-press
        if (w_off_press) begin
            w_mode_nxt = MODE_OFF;
        end else if (w_on_press) begin
            case (r_mode)
                MODE_OFF:    w_mode_nxt = MODE_STEADY;
                MODE_STEADY: w_mode_nxt = MODE_BLINK;
                MODE_BLINK:  w_mode_nxt = MODE_STEADY;
                default:     w_mode_nxt = MODE_OFF;
            endcase
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_mode      <= MODE_OFF;
            r_led_force <= 1'b0;
            r_blink_en  <= 1'b0;
            r_mode_chg  <= 1'b0;
        end else begin
            r_mode      <= w_mode_nxt;
            r_led_force <= (w_mode_nxt == MODE_STEADY);
            r_blink_en  <= (w_mode_nxt == MODE_BLINK);
            r_mode_chg  <= (w_mode_nxt != r_mode);
        end
    end

    assign mode      = r_mode;
    assign led_force = r_led_force;
    assign blink_en  = r_blink_en;
    assign mode_chg  = r_mode_chg;

endmodule
`default_nettype wire

// File: tb/tb_led_mode_ctrl.sv
`default_nettype none
// ============================================================================
// Module : tb_led_mode_ctrl
// Brief  : Directed self-checking bench for led_mode_ctrl (DEBOUNCE_CYCLES=4).
// Rev    : 1.0 - initial release
// ============================================================================
module tb_led_mode_ctrl;

    localparam int unsigned c_DEB = 4;
    localparam int unsigned c_CW  = 3;

    logic       clk;
    logic       rst_n;
    logic       btn_on;
    logic       btn_off;
    logic [1:0] mode;
    logic       led_force;
    logic       blink_en;
    logic       mode_chg;

    int n_cmp;
    int n_err;

    led_mode_ctrl #(
        .DEBOUNCE_CYCLES (c_DEB),
        .CNT_W           (c_CW)
    ) u_dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .btn_on    (btn_on),
        .btn_off   (btn_off),
        .mode      (mode),
        .led_force (led_force),
        .blink_en  (blink_en),
        .mode_chg  (mode_chg)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [7:0] got, input logic [7:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h (t=%0t)", tag, got, exp, $time);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Step n cycles; mode is m0 before cycle chg_at and m1 from it on (chg_at=0: never changes)
    task automatic watch(input string tag, input int n, input int chg_at,
                         input logic [1:0] m0, input logic [1:0] m1);
        logic [1:0] em;
        for (int k = 1; k <= n; k++) begin
            tick();
            em = (chg_at != 0 && k >= chg_at) ? m1 : m0;
            chk({tag, "_mode"}, {6'd0, mode}, {6'd0, em});
            chk({tag, "_chg"}, {7'd0, mode_chg}, {7'd0, (k == chg_at)});
            chk({tag, "_force"}, {7'd0, led_force}, {7'd0, (em == 2'b01)});
            chk({tag, "_blink"}, {7'd0, blink_en}, {7'd0, (em == 2'b10)});
        end
    endtask

    task automatic press_on(input string tag, input logic [1:0] m0, input logic [1:0] m1);
        btn_on = 1'b1;
        watch({tag, "_hold"}, 10, 8, m0, m1);
        btn_on = 1'b0;
        watch({tag, "_rel"}, 10, 0, m1, m1);
    endtask

    task automatic do_reset();
        rst_n = 1'b0;
        #1;
        chk("rst_async_mode", {6'd0, mode}, 8'd0);
        chk("rst_async_chg", {7'd0, mode_chg}, 8'd0);
        tick();
        tick();
        rst_n = 1'b1;
    endtask

    initial begin
        n_cmp   = 0;
        n_err   = 0;
        rst_n   = 1'b0;
        btn_on  = 1'b0;
        btn_off = 1'b0;
        tick();
        tick();
        tick();
        chk("reset_mode", {6'd0, mode}, 8'd0);
        chk("reset_force", {7'd0, led_force}, 8'd0);
        chk("reset_blink", {7'd0, blink_en}, 8'd0);
        chk("reset_chg", {7'd0, mode_chg}, 8'd0);
        rst_n = 1'b1;
        tick();

        // Held press: single event, mode change 8 cycles after rise
        btn_on = 1'b1;
        watch("hold", 20, 8, 2'b00, 2'b01);
        btn_on = 1'b0;
        watch("hold_rel", 12, 0, 2'b01, 2'b01);

        // Async reset from STEADY back to OFF
        tick();
        do_reset();
        watch("post_rst", 3, 0, 2'b00, 2'b00);

        // Bounce every 2 cycles never settles
        for (int i = 0; i < 16; i++) begin
            btn_on = ~btn_on;
            watch("bounce", 2, 0, 2'b00, 2'b00);
        end
        watch("bounce_end", 8, 0, 2'b00, 2'b00);

        // Clean presses: OFF->STEADY->BLINK->STEADY->BLINK
        press_on("p1", 2'b00, 2'b01);
        press_on("p2", 2'b01, 2'b10);
        press_on("p3", 2'b10, 2'b01);
        press_on("p4", 2'b01, 2'b10);

        // Coincident presses in BLINK: off wins, straight to OFF
        btn_on  = 1'b1;
        btn_off = 1'b1;
        watch("both", 10, 8, 2'b10, 2'b00);
        btn_on  = 1'b0;
        btn_off = 1'b0;
        watch("both_rel", 10, 0, 2'b00, 2'b00);

        // Off-press while already OFF
        btn_off = 1'b1;
        watch("off_in_off", 12, 0, 2'b00, 2'b00);
        btn_off = 1'b0;
        watch("off_in_off_rel", 10, 0, 2'b00, 2'b00);

        // Off-press from STEADY
        press_on("p5", 2'b00, 2'b01);
        btn_off = 1'b1;
        watch("off_steady", 10, 8, 2'b01, 2'b00);
        btn_off = 1'b0;
        watch("off_steady_rel", 10, 0, 2'b00, 2'b00);

        // Reset mid-debounce with button held through release
        press_on("p6", 2'b00, 2'b01);
        btn_on = 1'b1;
        watch("pre_rst", 2, 0, 2'b01, 2'b01);
        rst_n = 1'b0;
        #1;
        chk("mid_rst_mode", {6'd0, mode}, 8'd0);
        chk("mid_rst_force", {7'd0, led_force}, 8'd0);
        watch("in_rst", 3, 0, 2'b00, 2'b00);
        rst_n = 1'b1;
        watch("after_rst", 14, 8, 2'b00, 2'b01);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
`default_nettype wire
